// File: rtl/uart_rx_ctrl.sv
// Receive-side buffer between the UART byte receiver and the CPU: a small FIFO
// drained one byte at a time through an interrupt / rising-edge acknowledge handshake.
module uart_rx_ctrl #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_cpu_end_read,
   input  logic              i_flush,
   output logic [7:0]        o_cpu_data,
   output logic              o_cpu_int,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overrun
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t              r_state;
   state_t              w_state_next;
   logic [7:0]          r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_count;
   logic [7:0]          r_cpu_data;
   logic                r_cpu_int;
   logic                r_overrun;
   logic                r_ack_prev;
   logic                w_cpu_int_next;
   logic                w_ack_edge;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_fifo_full;
   logic                w_fifo_empty;

   assign w_fifo_full  = (r_count == C_DEPTH);
   assign w_fifo_empty = (r_count == '0);
   assign w_ack_edge   = i_cpu_end_read & ~r_ack_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cpu_int_next = r_cpu_int;
      w_pop          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop          = 1'b1;
               w_cpu_int_next = 1'b1;
               w_state_next   = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (w_ack_edge) begin
               w_cpu_int_next = 1'b0;
               w_state_next   = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      // Flush overrides any pop or handshake progress in the same cycle.
      if (i_flush) begin
         w_pop          = 1'b0;
         w_cpu_int_next = 1'b0;
         w_state_next   = ST_IDLE;
      end
   end

   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign w_push = i_rx_valid & ~i_flush & (~w_fifo_full | w_pop);
   assign w_drop = i_rx_valid & ~i_flush & w_fifo_full & ~w_pop;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_rx_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_cpu_data <= '0;
         r_cpu_int  <= 1'b0;
         r_overrun  <= 1'b0;
         r_ack_prev <= 1'b0;
      end else begin
         r_ack_prev <= i_cpu_end_read;
         r_cpu_int  <= w_cpu_int_next;
         if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               // Read-before-write: when full, head and tail share an entry.
               r_rd_ptr   <= r_rd_ptr + 1'b1;
               r_cpu_data <= r_mem[r_rd_ptr];
            end
            if (w_drop) begin
               r_overrun <= 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   assign o_cpu_data = r_cpu_data;
   assign o_cpu_int  = r_cpu_int;
   assign o_count    = r_count;
   assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: stimulus driven and outputs sampled on the falling edge.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       end_read;
   logic       flush;
   logic [7:0] cpu_data;
   logic       cpu_int;
   logic [2:0] count;
   logic       overrun;

   int n_cmp = 0;
   int n_mis = 0;

   uart_rx_ctrl #(.DEPTH(4), .ADDR_W(2)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rx_data      (rx_data),
      .i_rx_valid     (rx_valid),
      .i_cpu_end_read (end_read),
      .i_flush        (flush),
      .o_cpu_data     (cpu_data),
      .o_cpu_int      (cpu_int),
      .o_count        (count),
      .o_overrun      (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Acknowledge the presented byte and check the next one appears after one low cycle.
   task automatic ack_expect_next(input logic [7:0] exp_data, input logic [2:0] exp_count);
      @(negedge clk) end_read = 1'b1;
      @(negedge clk) end_read = 1'b0;
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL ack_gap cpu_int got %b want 0", cpu_int); end
      @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b1) begin n_mis++; $display("FAIL ack_next cpu_int got %b want 1", cpu_int); end
      n_cmp++; if (cpu_data !== exp_data) begin n_mis++; $display("FAIL ack_next cpu_data got %h want %h", cpu_data, exp_data); end
      n_cmp++; if (count !== exp_count) begin n_mis++; $display("FAIL ack_next count got %0d want %0d", count, exp_count); end
      $display("ack: data=%h int=%b count=%0d", cpu_data, cpu_int, count);
   endtask

   // Acknowledge the last byte: nothing further should be presented.
   task automatic ack_expect_empty();
      @(negedge clk) end_read = 1'b1;
      @(negedge clk) end_read = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL ack_empty cpu_int got %b want 0", cpu_int); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL ack_empty count got %0d want 0", count); end
      $display("ack last: int=%b count=%0d", cpu_int, count);
   endtask

   task automatic push_burst(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = first + 8'(i);
      end
      @(negedge clk) rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; end_read = 1'b0; flush = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (cpu_data !== 8'h00) begin n_mis++; $display("FAIL reset cpu_data got %h want 00", cpu_data); end
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL reset cpu_int got %b want 0", cpu_int); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL reset count got %0d want 0", count); end
      n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL reset overrun got %b want 0", overrun); end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: data=%h int=%b count=%0d ovr=%b", cpu_data, cpu_int, count, overrun);
   endtask

   task automatic test_single_byte();
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'hA5;
      @(negedge clk); rx_valid = 1'b0;
      n_cmp++; if (count !== 3'd1) begin n_mis++; $display("FAIL single_e0 count got %0d want 1", count); end
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL single_e0 cpu_int got %b want 0", cpu_int); end
      @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b1) begin n_mis++; $display("FAIL single_e1 cpu_int got %b want 1", cpu_int); end
      n_cmp++; if (cpu_data !== 8'hA5) begin n_mis++; $display("FAIL single_e1 cpu_data got %h want a5", cpu_data); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL single_e1 count got %0d want 0", count); end
      end_read = 1'b1;
      @(negedge clk); end_read = 1'b0;
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL single_ack cpu_int got %b want 0", cpu_int); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL single_ack count got %0d want 0", count); end
      $display("single: data=%h int=%b count=%0d", cpu_data, cpu_int, count);
      @(negedge clk);
   endtask

   task automatic test_order_wrap();
      push_burst(8'h01, 5);
      n_cmp++; if (cpu_data !== 8'h01) begin n_mis++; $display("FAIL order_fill cpu_data got %h want 01", cpu_data); end
      n_cmp++; if (cpu_int !== 1'b1) begin n_mis++; $display("FAIL order_fill cpu_int got %b want 1", cpu_int); end
      n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL order_fill count got %0d want 4", count); end
      n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL order_fill overrun got %b want 0", overrun); end
      $display("order fill: data=%h count=%0d ovr=%b", cpu_data, count, overrun);
      for (int k = 2; k <= 5; k++) ack_expect_next(8'(k), 3'(5 - k));
      ack_expect_empty();
      for (int b = 8'h11; b <= 8'h16; b++) begin
         @(negedge clk); rx_valid = 1'b1; rx_data = 8'(b);
         @(negedge clk); rx_valid = 1'b0;
         @(negedge clk);
         n_cmp++; if (cpu_data !== 8'(b) || cpu_int !== 1'b1) begin n_mis++; $display("FAIL wrap data got %h/%b want %h/1", cpu_data, cpu_int, 8'(b)); end
         end_read = 1'b1;
         @(negedge clk); end_read = 1'b0;
         n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL wrap_ack cpu_int got %b want 0", cpu_int); end
         $display("wrap: data=%h", cpu_data);
      end
   endtask

   task automatic test_overrun();
      push_burst(8'h21, 5);
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'hEE;
      @(negedge clk); rx_valid = 1'b0;
      n_cmp++; if (overrun !== 1'b1) begin n_mis++; $display("FAIL ovr_set overrun got %b want 1", overrun); end
      n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL ovr_set count got %0d want 4", count); end
      n_cmp++; if (cpu_data !== 8'h21) begin n_mis++; $display("FAIL ovr_set cpu_data got %h want 21", cpu_data); end
      $display("overrun: ovr=%b count=%0d data=%h", overrun, count, cpu_data);
      ack_expect_next(8'h22, 3'd3);
      ack_expect_next(8'h23, 3'd2);
      n_cmp++; if (overrun !== 1'b1) begin n_mis++; $display("FAIL ovr_sticky overrun got %b want 1", overrun); end
      // Flush with a coincident byte: byte discarded, overrun not set.
      @(negedge clk); flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
      @(negedge clk); flush = 1'b0; rx_valid = 1'b0;
      n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL flush overrun got %b want 0", overrun); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL flush count got %0d want 0", count); end
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL flush cpu_int got %b want 0", cpu_int); end
      n_cmp++; if (cpu_data !== 8'h23) begin n_mis++; $display("FAIL flush cpu_data got %h want 23", cpu_data); end
      repeat (2) @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b0 || count !== 3'd0 || overrun !== 1'b0) begin n_mis++; $display("FAIL flush_after int/count/ovr got %b/%0d/%b want 0/0/0", cpu_int, count, overrun); end
      $display("flush: int=%b count=%0d ovr=%b data=%h", cpu_int, count, overrun, cpu_data);
   endtask

   task automatic test_simul_push_pop();
      push_burst(8'h31, 5);
      @(negedge clk); end_read = 1'b1;
      @(negedge clk); end_read = 1'b0; rx_valid = 1'b1; rx_data = 8'h36;
      @(negedge clk); rx_valid = 1'b0;
      n_cmp++; if (count !== 3'd4) begin n_mis++; $display("FAIL simul count got %0d want 4", count); end
      n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL simul overrun got %b want 0", overrun); end
      n_cmp++; if (cpu_data !== 8'h32 || cpu_int !== 1'b1) begin n_mis++; $display("FAIL simul data got %h/%b want 32/1", cpu_data, cpu_int); end
      $display("simul: data=%h count=%0d ovr=%b", cpu_data, count, overrun);
      ack_expect_next(8'h33, 3'd3);
      ack_expect_next(8'h34, 3'd2);
      ack_expect_next(8'h35, 3'd1);
      ack_expect_next(8'h36, 3'd0);
   endtask

   task automatic test_ack_abuse();
      push_burst(8'h41, 2);
      @(negedge clk); end_read = 1'b1;
      repeat (10) @(negedge clk);
      n_cmp++; if (cpu_data !== 8'h41 || cpu_int !== 1'b1) begin n_mis++; $display("FAIL held_ack data got %h/%b want 41/1", cpu_data, cpu_int); end
      n_cmp++; if (count !== 3'd1) begin n_mis++; $display("FAIL held_ack count got %0d want 1", count); end
      $display("held ack: data=%h count=%0d", cpu_data, count);
      end_read = 1'b0;
      @(negedge clk);
      ack_expect_next(8'h42, 3'd0);
      ack_expect_empty();
      @(negedge clk); end_read = 1'b1;
      @(negedge clk); end_read = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b0 || count !== 3'd0 || cpu_data !== 8'h42) begin n_mis++; $display("FAIL idle_ack int/count/data got %b/%0d/%h want 0/0/42", cpu_int, count, cpu_data); end
      // The idle edge must not have armed a later pop: a new byte still presents normally.
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'h4F;
      @(negedge clk); rx_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_data !== 8'h4F || cpu_int !== 1'b1) begin n_mis++; $display("FAIL idle_ack_next data got %h/%b want 4f/1", cpu_data, cpu_int); end
      ack_expect_empty();
   endtask

   task automatic test_reset_mid();
      push_burst(8'h51, 4);
      n_cmp++; if (cpu_int !== 1'b1 || count !== 3'd3) begin n_mis++; $display("FAIL mid_setup int/count got %b/%0d want 1/3", cpu_int, count); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (cpu_int !== 1'b0) begin n_mis++; $display("FAIL mid_reset cpu_int got %b want 0", cpu_int); end
      n_cmp++; if (count !== 3'd0) begin n_mis++; $display("FAIL mid_reset count got %0d want 0", count); end
      n_cmp++; if (cpu_data !== 8'h00) begin n_mis++; $display("FAIL mid_reset cpu_data got %h want 00", cpu_data); end
      n_cmp++; if (overrun !== 1'b0) begin n_mis++; $display("FAIL mid_reset overrun got %b want 0", overrun); end
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (cpu_int !== 1'b0 || count !== 3'd0 || cpu_data !== 8'h00) begin n_mis++; $display("FAIL mid_after int/count/data got %b/%0d/%h want 0/0/00", cpu_int, count, cpu_data); end
      $display("reset mid: int=%b count=%0d data=%h", cpu_int, count, cpu_data);
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_order_wrap();
      test_overrun();
      test_simul_push_pop();
      test_ack_abuse();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
